// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit:
// access sizes, LSU FSM states, pipeline NOP and store-side lane helpers.
package mem_stage_lsu_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << off;
      SIZE_HALF: byte_en = 4'b0011 << off;
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could occupy.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: lane_data = {4{data[7:0]}};
      SIZE_HALF: lane_data = {2{data[15:0]}};
      default:   lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load formatter: picks the addressed lane(s) of the read word and
// sign/zero-extends them to 32 bits.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata >> {offset, 3'b000};

  // Lane extraction and extension by access size.
  always_comb begin
    result = rdata;
    case (size)
      SIZE_BYTE: result = {{24{sign & shifted_s[7]}}, shifted_s[7:0]};
      SIZE_HALF: result = {{16{sign & shifted_s[15]}}, shifted_s[15:0]};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per memory
// instruction, stalls the upstream pipeline until it completes or times out.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [1:0]            load_type,
  input  logic                  load_sign,
  mem_stage_lsu_if.master       dmem,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misalign,
  output logic                  bus_err
);

  lsu_state_e       state_r;
  logic [TO_W-1:0]  cnt_r;
  logic             req_r;
  logic             we_r;
  logic [31:0]      addr_r;
  logic [3:0]       be_r;
  logic [31:0]      wdata_r;
  logic [1:0]       off_r;
  logic [1:0]       size_r;
  logic             sign_r;
  logic [31:0]      load_data_r;
  logic             load_valid_r;
  logic             bus_err_r;
  logic             access_s;
  logic             misalign_s;
  logic [31:0]      aligned_s;

  assign access_s = mem_r | mem_w;

  // Alignment check only matters while a new instruction is being evaluated.
  always_comb begin
    misalign_s = 1'b0;
    if (state_r == ST_IDLE && access_s) begin
      case (load_type)
        SIZE_HALF: misalign_s = addr[0];
        SIZE_BYTE: misalign_s = 1'b0;
        default:   misalign_s = (addr[1:0] != 2'b00);
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end

  // Upstream hold: released in DONE so the next instruction advances.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      ST_IDLE: stall = access_s & ~misalign_s;
      ST_REQ:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  lsu_load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .offset (off_r),
    .size   (size_r),
    .sign   (sign_r),
    .result (aligned_s)
  );

  // Access FSM with all bus and result outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      be_r         <= 4'b0000;
      wdata_r      <= 32'h0000_0000;
      off_r        <= 2'b00;
      size_r       <= SIZE_WORD;
      sign_r       <= 1'b0;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_valid_r <= 1'b0;
          bus_err_r    <= 1'b0;
          if (access_s && !misalign_s) begin
            addr_r  <= {addr[31:2], 2'b00};
            be_r    <= byte_en(load_type, addr[1:0]);
            wdata_r <= lane_data(load_type, wdata);
            we_r    <= mem_w;
            off_r   <= addr[1:0];
            size_r  <= load_type;
            sign_r  <= load_sign;
            req_r   <= 1'b1;
            cnt_r   <= '0;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem.dmem_ack) begin
            req_r <= 1'b0;
            if (!we_r) begin
              load_data_r  <= aligned_s;
              load_valid_r <= 1'b1;
            end
            state_r <= ST_DONE;
          end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
            req_r       <= 1'b0;
            bus_err_r   <= 1'b1;
            load_data_r <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + TO_W'(1);
          end
        end
        ST_DONE: begin
          load_valid_r <= 1'b0;
          bus_err_r    <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_be    = be_r;
  assign dmem.dmem_wdata = wdata_r;
  assign load_data       = load_data_r;
  assign load_valid      = load_valid_r;
  assign bus_err         = bus_err_r;
  assign misalign        = misalign_s;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit; consumes the EXE/MEM pipeline register outputs and performs the data-memory access over a req/ack bus.
- Generates byte enables and store-data lane replication; aligns and sign/zero-extends load data.
- Drives a stall to freeze the PC, IF/ID, ID/EXE and EXE/MEM registers (CE low) while an access is outstanding.
- Results feed the MEM/WB register.

Parameters:
TIMEOUT, 16, max cycles waiting for dmem_ack before bus error (>=1)
TO_W, 5, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mem_r  in  1  load in MEM stage
mem_w  in  1  store in MEM stage
addr  in  32  byte address (EXE/MEM ALU result)
wdata  in  32  store data (EXE/MEM rs2 data)
load_type  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word); used for stores too
load_sign  in  1  1 sign-extend, 0 zero-extend (loads only)
dmem_req  out  1  bus request, registered
dmem_we  out  1  write enable, registered
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}, registered
dmem_be  out  4  byte enables, registered
dmem_wdata  out  32  lane-replicated store data, registered
dmem_ack  in  1  single-cycle completion
dmem_rdata  in  32  read word, valid with dmem_ack
stall  out  1  hold upstream pipeline, combinational
load_data  out  32  formatted load result, registered
load_valid  out  1  load_data valid (DONE cycle)
misalign  out  1  misaligned access flag, combinational
bus_err  out  1  timeout pulse, registered

Behaviour:
Reset: state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load_data=0, load_valid=0, bus_err=0, counter=0. stall=0 and misalign=0 follow from IDLE with no access.
- Reset mid-access abandons the transaction immediately: req drops, no ack is consumed.

access = mem_r | mem_w. If both are set, it is a store.

misalign (IDLE only):
- word with addr[1:0]!=0, or half with addr[0]!=0.
- A misaligned access issues no request and no stall; the pipeline proceeds and the instruction has no memory effect.

Byte enables (off = addr[1:0]):
- byte: 4'b0001<<off
- half: 4'b0011<<off
- word: 4'b1111

Store data:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata

Load data: select lane(s) of dmem_rdata by off; extend to 32 bits per load_sign.

FSM states:
- IDLE
  - stall = access & !misalign.
  - If so, at the clock edge: register addr/be/wdata, dmem_we=mem_w, dmem_req=1, counter=0, go REQ.
- REQ
  - stall=1; dmem_req held at 1 with outputs stable.
  - On dmem_ack: dmem_req<=0; if !dmem_we, load_data<=formatted rdata and load_valid<=1; go DONE.
  - Else if counter==TIMEOUT-1: dmem_req<=0, bus_err<=1, load_data<=0, go DONE.
  - Otherwise counter increments.
- DONE
  - stall=0 for exactly one cycle, so upstream registers advance at the end of this cycle.
  - load_valid=1 for loads; bus_err high only if the transaction timed out.
  - Next state IDLE; load_valid<=0, bus_err<=0.

Further rules:
- Latency: an access with ack in the first REQ cycle gives 2 stall cycles (IDLE, REQ), then DONE.
- An ack arriving in IDLE or DONE is ignored.
- The instruction captured in DONE is evaluated fresh in the next IDLE; back-to-back accesses never re-issue the previous one.
- A store sets load_valid=0 and leaves load_data unchanged.

Decomposition:
- Shared package: access-size encodings (SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10), FSM state encoding (IDLE/REQ/DONE, 2-bit), NOP instruction constant 32'h00000013 used by the pipeline registers.
- One sub-module: lsu_load_align (combinational: rdata, offset, size, sign -> 32-bit result). Byte-enable and store-data generation stay inline.

Test Plan:
- Signed byte load: mem_r=1, addr=0x1003, load_type=10, load_sign=1, ack after 1 cycle with rdata=0x80FF_1234 -> dmem_addr=0x1000, be=1000, stall 2 cycles, load_data=0xFFFF_FF80, load_valid pulse.
- Unsigned half load: addr=0x2002, type=01, sign=0, rdata=0xBEEF_0000 -> be=1100, load_data=0x0000_BEEF.
- Byte store: mem_w=1, addr=0x3001, type=10, wdata=0x0000_00A5 -> dmem_we=1, be=0010, dmem_wdata=0xA5A5_A5A5, load_valid=0.
- Misaligned word load: addr=0x4002, type=00 -> misalign=1, stall=0, dmem_req stays 0.
- Timeout: TIMEOUT=16, no ack -> dmem_req high 16 cycles, then bus_err pulse for 1 cycle in DONE, load_data=0, stall releases.
- Reset mid-REQ: assert rst while dmem_req=1 -> dmem_req=0 immediately, state IDLE; a later ack is ignored, no load_valid.
